// File: rtl/exec_pkg.sv
// Shared types for the multi-cycle execute unit.
// Opcodes, flag bit positions, FSM states and a flag packer.
package exec_pkg;

  localparam int OP_W    = 4;
  localparam int FLAGS_W = 5;

  localparam int FLAG_CF = 0;
  localparam int FLAG_PF = 1;
  localparam int FLAG_ZF = 2;
  localparam int FLAG_SF = 3;
  localparam int FLAG_OF = 4;

  typedef enum logic [OP_W-1:0] {
    OP_ADD,
    OP_SUB,
    OP_CMP,
    OP_AND,
    OP_OR,
    OP_XOR,
    OP_TEST,
    OP_MOV,
    OP_SHL,
    OP_SHR,
    OP_SAR,
    OP_IMUL,
    OP_NOP
  } exec_op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DONE
  } state_t;

  function automatic logic [FLAGS_W-1:0] mk_flags(
    input logic of,
    input logic sf,
    input logic zf,
    input logic pf,
    input logic cf
  );
    logic [FLAGS_W-1:0] f;
    f = '0;
    f[FLAG_OF] = of;
    f[FLAG_SF] = sf;
    f[FLAG_ZF] = zf;
    f[FLAG_PF] = pf;
    f[FLAG_CF] = cf;
    return f;
  endfunction

endpackage

// File: rtl/mod_imul_iter.sv
// Iterative signed multiplier, MUL_BITS multiplier bits per cycle.
// done is high in the last iteration; lo/hi then carry the final product.
module mod_imul_iter #(
  parameter int DATA_W   = 64,
  parameter int MUL_BITS = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              kill,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              done,
  output logic [DATA_W-1:0] lo,
  output logic [DATA_W-1:0] hi
);

  localparam int STEPS = DATA_W / MUL_BITS;
  localparam int CW    = $clog2(STEPS) + 1;
  localparam int PW    = 2 * DATA_W;

  logic [PW-1:0]     acc;
  logic [PW-1:0]     acc_nxt;
  logic [PW-1:0]     mcand;
  logic [PW-1:0]     a_ext;
  logic [PW-1:0]     a_corr;
  logic [DATA_W-1:0] mplier;
  logic [CW-1:0]     cnt;
  logic              run;

  // b is walked as unsigned; a negative b is fixed by
  // preloading -a*2^DATA_W into the accumulator.
  assign a_ext  = {{DATA_W{a[DATA_W-1]}}, a};
  assign a_corr = {a, {DATA_W{1'b0}}};

  // One shift-add step over the low MUL_BITS multiplier bits.
  always_comb begin
    acc_nxt = acc;
    for (int k = 0; k < MUL_BITS; k++) begin
      if (mplier[k]) begin
        acc_nxt = acc_nxt + (mcand << k);
      end
    end
  end

  // Iteration state: accumulator, shifted operands, step counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      run    <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (kill) begin
      run <= 1'b0;
      cnt <= '0;
    end else if (start) begin
      acc    <= b[DATA_W-1] ? ('0 - a_corr) : '0;
      mcand  <= a_ext;
      mplier <= b;
      cnt    <= CW'(STEPS);
      run    <= 1'b1;
    end else if (run) begin
      acc    <= acc_nxt;
      mcand  <= mcand << MUL_BITS;
      mplier <= mplier >> MUL_BITS;
      cnt    <= cnt - CW'(1);
      run    <= (cnt != CW'(1));
    end
  end

  assign done = run && (cnt == CW'(1));
  assign lo   = acc_nxt[DATA_W-1:0];
  assign hi   = acc_nxt[PW-1:DATA_W];

endmodule

// File: rtl/mod_execute_mc.sv
// Multi-cycle integer execute stage: ALU, barrel shifter, iterative
// IMUL and RFLAGS, with valid/ready on both sides and flush.
module mod_execute_mc
  import exec_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter int MUL_BITS = 2,
  parameter int TAG_W    = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  exec_op_t           in_op,
  input  logic [DATA_W-1:0]  in_a,
  input  logic [DATA_W-1:0]  in_b,
  input  logic [TAG_W-1:0]   in_dst,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_result,
  output logic [DATA_W-1:0]  out_ext,
  output logic [TAG_W-1:0]   out_dst,
  output logic               out_wr_en,
  output logic [FLAGS_W-1:0] out_flags,
  output logic               out_flags_we,
  output logic               busy
);

  localparam int SH_W = $clog2(DATA_W);
  localparam int M    = DATA_W - 1;

  state_t state;
  state_t state_nxt;

  logic              accept;
  logic              is_mul;
  logic              mul_done;
  logic              mul_ov;
  logic [DATA_W-1:0] mul_lo;
  logic [DATA_W-1:0] mul_hi;

  logic [SH_W-1:0]   sh_cnt;
  logic              sh_one;
  logic [DATA_W:0]   sum_w;
  logic [DATA_W:0]   dif_w;
  logic [DATA_W:0]   shl_w;
  logic [DATA_W:0]   shr_w;
  logic [DATA_W:0]   sar_w;

  logic [DATA_W-1:0] alu_res;
  logic              alu_cf;
  logic              alu_of;
  logic              alu_wr;
  logic              alu_fwe;

  assign accept = in_valid && in_ready && !flush;
  assign is_mul = (in_op == OP_IMUL);

  assign sh_cnt = in_b[SH_W-1:0];
  assign sh_one = (sh_cnt == SH_W'(1));
  assign sum_w  = {1'b0, in_a} + {1'b0, in_b};
  assign dif_w  = {1'b0, in_a} - {1'b0, in_b};
  assign shl_w  = {1'b0, in_a} << sh_cnt;
  assign shr_w  = {in_a, 1'b0} >> sh_cnt;
  assign sar_w  = $unsigned($signed({in_a, 1'b0}) >>> sh_cnt);

  assign mul_ov = (mul_hi != {DATA_W{mul_lo[M]}});

  mod_imul_iter #(
    .DATA_W   (DATA_W),
    .MUL_BITS (MUL_BITS)
  ) u_imul (
    .clk   (clk),
    .reset (reset),
    .kill  (flush),
    .start (accept && is_mul),
    .a     (in_a),
    .b     (in_b),
    .done  (mul_done),
    .lo    (mul_lo),
    .hi    (mul_hi)
  );

  // Single-cycle ALU and shifter for everything except IMUL.
  always_comb begin
    alu_res = '0;
    alu_cf  = 1'b0;
    alu_of  = 1'b0;
    alu_wr  = 1'b1;
    alu_fwe = 1'b1;
    unique case (in_op)
      OP_ADD: begin
        alu_res = sum_w[M:0];
        alu_cf  = sum_w[DATA_W];
        alu_of  = (in_a[M] == in_b[M]) && (alu_res[M] != in_a[M]);
      end
      OP_SUB, OP_CMP: begin
        alu_res = dif_w[M:0];
        alu_cf  = dif_w[DATA_W];
        alu_of  = (in_a[M] != in_b[M]) && (alu_res[M] != in_a[M]);
        alu_wr  = (in_op == OP_SUB);
      end
      OP_AND, OP_TEST: begin
        alu_res = in_a & in_b;
        alu_wr  = (in_op == OP_AND);
      end
      OP_OR:  alu_res = in_a | in_b;
      OP_XOR: alu_res = in_a ^ in_b;
      OP_MOV: begin
        alu_res = in_b;
        alu_fwe = 1'b0;
      end
      OP_SHL: begin
        alu_res = shl_w[M:0];
        alu_cf  = shl_w[DATA_W];
        alu_of  = sh_one && (shl_w[M] ^ shl_w[DATA_W]);
        alu_fwe = (sh_cnt != '0);
      end
      OP_SHR: begin
        alu_res = shr_w[DATA_W:1];
        alu_cf  = shr_w[0];
        alu_of  = sh_one && in_a[M];
        alu_fwe = (sh_cnt != '0);
      end
      OP_SAR: begin
        alu_res = sar_w[DATA_W:1];
        alu_cf  = sar_w[0];
        alu_fwe = (sh_cnt != '0);
      end
      default: begin
        alu_wr  = 1'b0;
        alu_fwe = 1'b0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state; flush dominates everything but reset.
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (accept) state_nxt = is_mul ? S_MUL : S_DONE;
        end
        S_MUL: begin
          if (mul_done) state_nxt = S_DONE;
        end
        S_DONE: begin
          if (accept) state_nxt = is_mul ? S_MUL : S_DONE;
          else if (out_ready) state_nxt = S_IDLE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // FSM outputs; a completing result can be replaced in the same cycle.
  always_comb begin
    out_valid = (state == S_DONE);
    busy      = (state != S_IDLE);
    in_ready  = (state == S_IDLE) || ((state == S_DONE) && out_ready);
  end

  // Result/flags register, loaded at ALU accept or final IMUL step.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_result   <= '0;
      out_ext      <= '0;
      out_dst      <= '0;
      out_wr_en    <= 1'b0;
      out_flags    <= '0;
      out_flags_we <= 1'b0;
    end else if (flush) begin
      out_wr_en    <= 1'b0;
      out_flags_we <= 1'b0;
    end else if (accept && !is_mul) begin
      out_result   <= alu_res;
      out_ext      <= '0;
      out_dst      <= in_dst;
      out_wr_en    <= alu_wr;
      out_flags_we <= alu_fwe;
      out_flags    <= mk_flags(alu_of, alu_res[M], ~|alu_res,
                               ~^alu_res[7:0], alu_cf);
    end else if (accept) begin
      out_dst <= in_dst;
    end else if ((state == S_MUL) && mul_done) begin
      out_result   <= mul_lo;
      out_ext      <= mul_hi;
      out_wr_en    <= 1'b1;
      out_flags_we <= 1'b1;
      out_flags    <= mk_flags(mul_ov, mul_lo[M], ~|mul_lo,
                               ~^mul_lo[7:0], mul_ov);
    end
  end

endmodule

// File: tb/tb_mod_execute_mc.sv
// Bench for mod_execute_mc: vector table, corner sequences and
// random ops checked against an arithmetic reference model.
module tb_mod_execute_mc;
  import exec_pkg::*;

  localparam int W    = 64;
  localparam int MB   = 2;
  localparam int TW   = 4;
  localparam int MLAT = W / MB + 1;

  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] ext;
    logic         wr;
    logic         fwe;
    logic [4:0]   flags;
  } exp_t;

  typedef struct {
    exec_op_t     op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    exp_t         e;
    int           lat;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  exec_op_t      in_op = OP_NOP;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  in_b = '0;
  logic [TW-1:0] in_dst = '0;
  logic          flush = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  out_result;
  logic [W-1:0]  out_ext;
  logic [TW-1:0] out_dst;
  logic          out_wr_en;
  logic [4:0]    out_flags;
  logic          out_flags_we;
  logic          busy;

  int checks = 0;
  int errors = 0;

  mod_execute_mc #(
    .DATA_W   (W),
    .MUL_BITS (MB),
    .TAG_W    (TW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_op        (in_op),
    .in_a         (in_a),
    .in_b         (in_b),
    .in_dst       (in_dst),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_ext      (out_ext),
    .out_dst      (out_dst),
    .out_wr_en    (out_wr_en),
    .out_flags    (out_flags),
    .out_flags_we (out_flags_we),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  function automatic void chk(string nm, logic [W-1:0] act,
                              logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endfunction

  function automatic exp_t model(exec_op_t op, logic [W-1:0] a,
                                 logic [W-1:0] b);
    exp_t e;
    logic [W-1:0] r;
    logic cf, of;
    logic signed [W+1:0] t;
    logic signed [2*W-1:0] p;
    int n;
    e.ext = '0; e.wr = 1'b1; e.fwe = 1'b1;
    r = '0; cf = 1'b0; of = 1'b0;
    case (op)
      OP_ADD: begin
        r  = a + b;
        cf = (r < a);
        t  = $signed({{2{a[W-1]}}, a}) + $signed({{2{b[W-1]}}, b});
        of = (t != $signed({{2{r[W-1]}}, r}));
      end
      OP_SUB, OP_CMP: begin
        r  = a - b;
        cf = (a < b);
        t  = $signed({{2{a[W-1]}}, a}) - $signed({{2{b[W-1]}}, b});
        of = (t != $signed({{2{r[W-1]}}, r}));
        e.wr = (op == OP_SUB);
      end
      OP_AND: r = a & b;
      OP_TEST: begin r = a & b; e.wr = 1'b0; end
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      OP_MOV: begin r = b; e.fwe = 1'b0; end
      OP_SHL, OP_SHR, OP_SAR: begin
        n = int'(b[5:0]);
        r = a;
        for (int i = 0; i < n; i++) begin
          if (op == OP_SHL) begin
            cf = r[W-1]; r = r << 1;
          end else if (op == OP_SHR) begin
            cf = r[0]; r = r >> 1;
          end else begin
            cf = r[0]; r = {r[W-1], r[W-1:1]};
          end
        end
        if (n == 1) begin
          if (op == OP_SHL) of = r[W-1] ^ cf;
          else if (op == OP_SHR) of = a[W-1];
        end
        if (n == 0) e.fwe = 1'b0;
      end
      OP_IMUL: begin
        p = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
        r = p[W-1:0];
        e.ext = p[2*W-1:W];
        of = (p != $signed({{W{r[W-1]}}, r}));
        cf = of;
      end
      default: begin e.wr = 1'b0; e.fwe = 1'b0; end
    endcase
    e.res = r;
    e.flags = {of, r[W-1], (r == '0), ~^r[7:0], cf};
    return e;
  endfunction

  task automatic run_op(input exec_op_t op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [TW-1:0] dst,
                        output int lat, output logic rdy_seen);
    int w;
    in_op = op; in_a = a; in_b = b; in_dst = dst; in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 100) begin
      @(posedge clk); #1; w++;
    end
    chk("accept_wait", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    rdy_seen = 1'b0;
    while (!out_valid && lat < 200) begin
      if (in_ready) rdy_seen = 1'b1;
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic check_out(string nm, exp_t e, logic [TW-1:0] dst,
                           int lat, int elat);
    chk({nm, " valid"}, {63'd0, out_valid}, 64'd1);
    chk({nm, " lat"}, W'(lat), W'(elat));
    chk({nm, " dst"}, W'(out_dst), W'(dst));
    chk({nm, " wr_en"}, {63'd0, out_wr_en}, {63'd0, e.wr});
    chk({nm, " flags_we"}, {63'd0, out_flags_we}, {63'd0, e.fwe});
    if (e.wr) chk({nm, " result"}, out_result, e.res);
    chk({nm, " ext"}, out_ext, e.ext);
    if (e.fwe) chk({nm, " flags"}, W'(out_flags), W'(e.flags));
  endtask

  vec_t vt[15];

  initial begin
    int lat;
    logic rs;
    logic seen;
    exp_t e;
    exec_op_t op;
    logic [W-1:0] a, b;

    vt[0]  = '{OP_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1,
               '{64'h8000_0000_0000_0000, 64'd0, 1'b1, 1'b1, 5'b11010}, 1};
    vt[1]  = '{OP_CMP, 64'd5, 64'd5,
               '{64'd0, 64'd0, 1'b0, 1'b1, 5'b00110}, 1};
    vt[2]  = '{OP_CMP, 64'd3, 64'd5,
               '{64'hFFFF_FFFF_FFFF_FFFE, 64'd0, 1'b0, 1'b1, 5'b01001}, 1};
    vt[3]  = '{OP_IMUL, 64'hFFFF_FFFF_FFFF_FFFD, 64'h4000_0000_0000_0000,
               '{64'h4000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                 1'b1, 1'b1, 5'b10011}, MLAT};
    vt[4]  = '{OP_SAR, 64'h8000_0000_0000_0010, 64'd68,
               '{64'hF800_0000_0000_0001, 64'd0, 1'b1, 1'b1, 5'b01000}, 1};
    vt[5]  = '{OP_SHL, 64'h1234, 64'd0,
               '{64'h1234, 64'd0, 1'b1, 1'b0, 5'b00000}, 1};
    vt[6]  = '{OP_SUB, 64'd0, 64'd1,
               '{64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b1, 5'b01011}, 1};
    vt[7]  = '{OP_XOR, 64'hA5A5, 64'hA5A5,
               '{64'd0, 64'd0, 1'b1, 1'b1, 5'b00110}, 1};
    vt[8]  = '{OP_TEST, 64'hF0, 64'h0F,
               '{64'd0, 64'd0, 1'b0, 1'b1, 5'b00110}, 1};
    vt[9]  = '{OP_MOV, 64'h1, 64'hDEAD,
               '{64'hDEAD, 64'd0, 1'b1, 1'b0, 5'b00000}, 1};
    vt[10] = '{OP_SHL, 64'h8000_0000_0000_0001, 64'd1,
               '{64'd2, 64'd0, 1'b1, 1'b1, 5'b10001}, 1};
    vt[11] = '{OP_SHR, 64'h8000_0000_0000_0003, 64'd1,
               '{64'h4000_0000_0000_0001, 64'd0, 1'b1, 1'b1, 5'b10001}, 1};
    vt[12] = '{OP_NOP, 64'h5, 64'h6,
               '{64'd0, 64'd0, 1'b0, 1'b0, 5'b00000}, 1};
    vt[13] = '{OP_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,
               '{64'd0, 64'd0, 1'b1, 1'b1, 5'b00111}, 1};
    vt[14] = '{OP_IMUL, 64'd7, 64'd6,
               '{64'd42, 64'd0, 1'b1, 1'b1, 5'b00000}, MLAT};

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst valid", {63'd0, out_valid}, 64'd0);
    chk("rst busy", {63'd0, busy}, 64'd0);
    chk("rst in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst result", out_result, 64'd0);
    chk("rst ext", out_ext, 64'd0);
    chk("rst flags", W'(out_flags), 64'd0);
    chk("rst dst", W'(out_dst), 64'd0);
    chk("rst wr", {62'd0, out_wr_en, out_flags_we}, 64'd0);

    for (int i = 0; i < 15; i++) begin
      run_op(vt[i].op, vt[i].a, vt[i].b, TW'(i), lat, rs);
      check_out($sformatf("vec%0d", i), vt[i].e, TW'(i), lat, vt[i].lat);
      if (vt[i].op == OP_IMUL)
        chk($sformatf("vec%0d busy_ready", i), {63'd0, rs}, 64'd0);
    end
    @(posedge clk); #1;

    // back-pressure then queued XOR with no bubble
    out_ready = 1'b0;
    e = model(OP_ADD, 64'd100, 64'd23);
    run_op(OP_ADD, 64'd100, 64'd23, 4'd5, lat, rs);
    check_out("bp add", e, 4'd5, lat, 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp hold valid", {63'd0, out_valid}, 64'd1);
      chk("bp hold ready", {63'd0, in_ready}, 64'd0);
      chk("bp hold result", out_result, 64'd123);
      chk("bp hold flags", W'(out_flags), W'(e.flags));
      chk("bp hold dst", W'(out_dst), 64'd5);
    end
    in_op = OP_XOR; in_a = 64'hFF00; in_b = 64'h0FF0; in_dst = 4'd6;
    in_valid = 1'b1;
    #1 chk("bp queued ready", {63'd0, in_ready}, 64'd0);
    out_ready = 1'b1;
    #1 chk("bp release ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp xor valid", {63'd0, out_valid}, 64'd1);
    chk("bp xor result", out_result, 64'hF0F0);
    chk("bp xor dst", W'(out_dst), 64'd6);
    @(posedge clk); #1;
    chk("bp drained", {63'd0, out_valid}, 64'd0);

    // flush ten cycles into IMUL
    in_op = OP_IMUL; in_a = 64'd7; in_b = 64'd9; in_dst = 4'd3;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("fl busy", {63'd0, busy}, 64'd1);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("fl busy after", {63'd0, busy}, 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    chk("fl no valid", {63'd0, seen}, 64'd0);

    // accept in the flush cycle is ignored
    in_op = OP_ADD; in_a = 64'd1; in_b = 64'd2; in_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("fl accept valid", {63'd0, out_valid}, 64'd0);
    chk("fl accept busy", {63'd0, busy}, 64'd0);

    // reset during S_MUL
    in_op = OP_IMUL; in_a = 64'hFFFF_FFFF_FFFF_FFFD; in_b = 64'd5;
    in_dst = 4'd9; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("mr busy", {63'd0, busy}, 64'd0);
    chk("mr valid", {63'd0, out_valid}, 64'd0);
    chk("mr result", out_result, 64'd0);
    chk("mr ext", out_ext, 64'd0);
    chk("mr flags", W'(out_flags), 64'd0);
    chk("mr dst", W'(out_dst), 64'd0);
    chk("mr we", {62'd0, out_wr_en, out_flags_we}, 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    chk("mr no valid", {63'd0, seen}, 64'd0);

    // random operations against the reference model
    for (int i = 0; i < 200; i++) begin
      op = exec_op_t'(OP_W'($urandom_range(0, 12)));
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      if (op inside {OP_SHL, OP_SHR, OP_SAR})
        b = W'($urandom_range(0, 130));
      if ($urandom_range(0, 7) == 0) a = W'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) b = a;
      e = model(op, a, b);
      run_op(op, a, b, TW'(i), lat, rs);
      check_out($sformatf("rnd%0d %s", i, op.name()), e, TW'(i), lat,
                (op == OP_IMUL) ? MLAT : 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
